// File: rtl/mul_arbiter_if.sv
// Operand payload type and the pipe/core-facing bundle of the shared multiplier arbiter.
package mul_arbiter_pkg;
  localparam int unsigned DATA_W = 32;

  // Issue payload from an execute pipe, packed {use_high, is_unsigned, x, y}
  typedef struct packed {
    logic              use_high;
    logic              is_unsigned;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } mul_op_t;
endpackage

interface mul_arbiter_if;
  logic                     flush;
  logic                     req1_valid;
  mul_arbiter_pkg::mul_op_t req1_bus;
  logic                     req1_ready;
  logic                     req2_valid;
  mul_arbiter_pkg::mul_op_t req2_bus;
  logic                     req2_ready;
  logic                     rsp1_valid;
  logic                     rsp2_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_data;
  logic                     mul_en;
  logic                     mul_signed;
  logic                     mul_use_high;
  logic [31:0]              mul_x;
  logic [31:0]              mul_y;
  logic                     mul_ok;
  logic [31:0]              mul_result;
  logic                     busy;
  logic                     timeout_err;

  // Arbiter side
  modport slave (
    input  flush, req1_valid, req1_bus, req2_valid, req2_bus, rsp_ready, mul_ok, mul_result,
    output req1_ready, req2_ready, rsp1_valid, rsp2_valid, rsp_data,
           mul_en, mul_signed, mul_use_high, mul_x, mul_y, busy, timeout_err
  );

  // Pipes and multiplier core side
  modport master (
    output flush, req1_valid, req1_bus, req2_valid, req2_bus, rsp_ready, mul_ok, mul_result,
    input  req1_ready, req2_ready, rsp1_valid, rsp2_valid, rsp_data,
           mul_en, mul_signed, mul_use_high, mul_x, mul_y, busy, timeout_err
  );
endinterface

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between two execute pipes with a one-entry response buffer.
module mul_arbiter #(
  parameter bit          FIXED_PRI = 1'b0,
  parameter int unsigned TIMEOUT   = 15
) (
  input logic          clk,
  input logic          reset,
  mul_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = mul_arbiter_pkg::DATA_W;
  localparam int unsigned WDOG_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  mul_arbiter_pkg::mul_op_t grant_op;
  logic                     grant_any;
  logic                     grant_sel;   // 0 = pipe1, 1 = pipe2
  logic                     last_grant;  // 0 = pipe1, 1 = pipe2
  logic                     owner;       // 0 = pipe1, 1 = pipe2
  logic                     op_signed;
  logic                     op_use_high;
  logic [DATA_W-1:0]        op_x;
  logic [DATA_W-1:0]        op_y;
  logic [DATA_W-1:0]        rsp_q;
  logic                     timeout_q;
  logic [WDOG_W-1:0]        wdog;
  logic                     wdog_expire;

  assign wdog_expire = (wdog == WDOG_W'(TIMEOUT - 1));
  assign grant_op    = grant_sel ? bus.req2_bus : bus.req1_bus;

  // Core operands come straight from the op registers so they stay stable through BUSY
  assign bus.mul_signed   = op_signed;
  assign bus.mul_use_high = op_use_high;
  assign bus.mul_x        = op_x;
  assign bus.mul_y        = op_y;
  assign bus.rsp_data     = rsp_q;
  assign bus.timeout_err  = timeout_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides every other event
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (grant_any) state_next = BUSY;
        BUSY: begin
          if (bus.mul_ok)       state_next = RESP;
          else if (wdog_expire) state_next = IDLE;
        end
        RESP: if (bus.rsp_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs and grant selection
  always_comb begin
    grant_any      = 1'b0;
    grant_sel      = 1'b0;
    bus.req1_ready = 1'b0;
    bus.req2_ready = 1'b0;
    bus.mul_en     = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp2_valid = 1'b0;
    bus.busy       = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush) begin
          grant_any      = bus.req1_valid | bus.req2_valid;
          // pipe2 wins when alone, or on a tie under round-robin after a pipe1 grant
          grant_sel      = bus.req2_valid & (~bus.req1_valid | (~FIXED_PRI & ~last_grant));
          bus.req1_ready = grant_any & ~grant_sel;
          bus.req2_ready = grant_sel;
        end
      end
      BUSY: begin
        bus.mul_en = 1'b1;
        bus.busy   = 1'b1;
      end
      RESP: begin
        bus.rsp1_valid = ~owner;
        bus.rsp2_valid = owner;
        bus.busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Op latch, ownership, result capture and watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      op_signed   <= 1'b0;
      op_use_high <= 1'b0;
      op_x        <= '0;
      op_y        <= '0;
      rsp_q       <= '0;
      timeout_q   <= 1'b0;
      wdog        <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (bus.flush) begin
        wdog <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (grant_any) begin
              op_signed   <= ~grant_op.is_unsigned;
              op_use_high <= grant_op.use_high;
              op_x        <= grant_op.x;
              op_y        <= grant_op.y;
              owner       <= grant_sel;
              last_grant  <= grant_sel;
              wdog        <= '0;
            end
          end
          BUSY: begin
            if (bus.mul_ok) begin
              rsp_q <= bus.mul_result;
              wdog  <= '0;
            end else if (wdog_expire) begin
              wdog      <= '0;
              timeout_q <= 1'b1;
            end else begin
              wdog <= wdog + WDOG_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: round-robin and fixed-priority instances with a 2-cycle core model.
`timescale 1ns/1ps
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  typedef struct {
    bit          pipe;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  logic ph_a;
  logic ph_f;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  exp_t sb[$];

  mul_arbiter_if a();
  mul_arbiter_if f();

  mul_arbiter #(.FIXED_PRI(1'b0), .TIMEOUT(15)) u_dut (.clk(clk), .reset(reset), .bus(a));
  mul_arbiter #(.FIXED_PRI(1'b1), .TIMEOUT(15)) u_fix (.clk(clk), .reset(reset), .bus(f));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference product with the requested signedness and half
  function automatic logic [31:0] ref_mul(input logic sgn, input logic hi,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye, p;
    xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
    p  = xe * ye;
    return hi ? p[63:32] : p[31:0];
  endfunction

  // Two-cycle core models: mul_ok on the second enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_a <= 1'b0;
      ph_f <= 1'b0;
    end else begin
      ph_a <= a.mul_en & ~ph_a;
      ph_f <= f.mul_en & ~ph_f;
    end
  end
  assign a.mul_ok     = a.mul_en & ph_a & ~stall;
  assign a.mul_result = ref_mul(a.mul_signed, a.mul_use_high, a.mul_x, a.mul_y);
  assign f.mul_ok     = f.mul_en & ph_f & ~stall;
  assign f.mul_result = ref_mul(f.mul_signed, f.mul_use_high, f.mul_x, f.mul_y);

  // Fixed-priority instance sees the same requests and always takes responses
  assign f.flush      = a.flush;
  assign f.req1_valid = a.req1_valid;
  assign f.req1_bus   = a.req1_bus;
  assign f.req2_valid = a.req2_valid;
  assign f.req2_bus   = a.req2_bus;
  assign f.rsp_ready  = 1'b1;

  function automatic logic [31:0] op_exp(input mul_op_t op);
    return ref_mul(~op.is_unsigned, op.use_high, op.x, op.y);
  endfunction

  // Issue one op on a pipe, push its expectation on grant, return the response seen
  task automatic run_op(input bit pipe, input mul_op_t op, output int t_grant, output int t_rsp,
                        output logic [31:0] data, output bit rpipe, output bit ok);
    bit   granted;
    exp_t e;
    granted = 1'b0;
    t_grant = -1; t_rsp = -1; data = '0; rpipe = 1'b0; ok = 1'b0;
    @(posedge clk); #1;
    if (pipe) begin a.req2_valid = 1'b1; a.req2_bus = op; end
    else      begin a.req1_valid = 1'b1; a.req1_bus = op; end
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if ((pipe ? a.req2_ready : a.req1_ready) === 1'b1) begin
        granted = 1'b1;
        t_grant = cyc;
        e.pipe = pipe; e.data = op_exp(op);
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    a.req1_valid = 1'b0;
    a.req2_valid = 1'b0;
    if (!granted) return;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a.rsp1_valid === 1'b1 || a.rsp2_valid === 1'b1) begin
        t_rsp = cyc; data = a.rsp_data; rpipe = a.rsp2_valid; ok = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bit          seen;
    a.flush = 1'b0; a.req1_valid = 1'b0; a.req2_valid = 1'b0; a.rsp_ready = 1'b1;
    a.req1_bus = '0; a.req2_bus = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({a.busy, a.mul_en, a.rsp1_valid, a.rsp2_valid, a.timeout_err, a.mul_signed,
         a.mul_use_high} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 0000000", {a.busy, a.mul_en, a.rsp1_valid,
               a.rsp2_valid, a.timeout_err, a.mul_signed, a.mul_use_high});
    end
    vectors++;
    if ({a.mul_x, a.mul_y, a.rsp_data} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {a.mul_x, a.mul_y, a.rsp_data});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    // First tie after reset goes to pipe1
    @(posedge clk); #1;
    a.req1_valid = 1'b1; a.req1_bus = '{use_high: 1'b0, is_unsigned: 1'b1, x: 32'd2, y: 32'd3};
    a.req2_valid = 1'b1; a.req2_bus = '{use_high: 1'b0, is_unsigned: 1'b1, x: 32'd4, y: 32'd5};
    @(negedge clk);
    vectors++;
    if ({a.req1_ready, a.req2_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL first_tie: got %b required 10", {a.req1_ready, a.req2_ready});
    end
    @(posedge clk); #1;
    a.req1_valid = 1'b0; a.req2_valid = 1'b0;
    seen = 1'b0; d = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (a.rsp1_valid === 1'b1) begin seen = 1'b1; d = a.rsp_data; end
    end
    vectors++;
    if (!seen || d !== 32'd6) begin
      miscompares++;
      $display("FAIL first_tie_rsp: got seen=%0d data=%h required seen=1 data=00000006", seen, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int          tg, tr;
    logic [31:0] d;
    bit          rp, ok;
    exp_t        e;
    run_op(1'b0, '{use_high: 1'b0, is_unsigned: 1'b0, x: 32'd7, y: 32'd6}, tg, tr, d, rp, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done: got %0d required 1", ok);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (rp !== e.pipe || d !== e.data) begin
        miscompares++;
        $display("FAIL single_rsp: got pipe%0d %h required pipe%0d %h", rp + 1, d, e.pipe + 1, e.data);
      end
      vectors++;
      if (d !== 32'd42) begin
        miscompares++;
        $display("FAIL single_42: got %h required 0000002a", d);
      end
      vectors++;
      if (tr - tg !== 3) begin
        miscompares++;
        $display("FAIL single_latency: got %0d required 3", tr - tg);
      end
    end
  endtask

  task automatic test_pipe2();
    int          tg, tr;
    logic [31:0] d;
    bit          rp, ok;
    exp_t        e;
    logic [31:0] want [2];
    want[0] = 32'h0000_0001;
    want[1] = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      run_op(1'b1, '{use_high: 1'b1, is_unsigned: (k == 0), x: 32'hFFFF_FFFF, y: 32'd2},
             tg, tr, d, rp, ok);
      vectors++;
      if (ok !== 1'b1) begin
        miscompares++;
        $display("FAIL pipe2_done[%0d]: got %0d required 1", k, ok);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (rp !== 1'b1 || rp !== e.pipe || d !== e.data || d !== want[k]) begin
          miscompares++;
          $display("FAIL pipe2_rsp[%0d]: got pipe%0d %h required pipe2 %h", k, rp + 1, d, want[k]);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    bit      exp_next, gp;
    int      grants, fix_grants, last_t;
    exp_t    e;
    mul_op_t o1, o2;
    exp_next = 1'b0; grants = 0; fix_grants = 0; last_t = -1;
    o1 = '{use_high: 1'b0, is_unsigned: 1'b0, x: 32'd3, y: 32'd5};
    o2 = '{use_high: 1'b0, is_unsigned: 1'b0, x: 32'hFFFF_FFFC, y: 32'd9};
    @(posedge clk); #1;
    a.req1_valid = 1'b1; a.req2_valid = 1'b1; a.req1_bus = o1; a.req2_bus = o2;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      vectors++;
      if (a.rsp1_valid === 1'b1 && a.rsp2_valid === 1'b1) begin
        miscompares++;
        $display("FAIL rsp_onehot: got 11 required at most one valid");
      end
      if (a.rsp1_valid === 1'b1 || a.rsp2_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL arb_rsp: got unexpected response %h required none", a.rsp_data);
        end else begin
          e = sb.pop_front();
          if (a.rsp2_valid !== e.pipe || a.rsp_data !== e.data) begin
            miscompares++;
            $display("FAIL arb_rsp: got pipe%0d %h required pipe%0d %h",
                     a.rsp2_valid + 1, a.rsp_data, e.pipe + 1, e.data);
          end
        end
      end
      if (a.req1_ready === 1'b1 || a.req2_ready === 1'b1) begin
        gp = a.req2_ready;
        vectors++;
        if (gp !== exp_next) begin
          miscompares++;
          $display("FAIL rr_order: got pipe%0d required pipe%0d", gp + 1, exp_next + 1);
        end
        if (last_t >= 0) begin
          vectors++;
          if (cyc - last_t !== 4) begin
            miscompares++;
            $display("FAIL issue_interval: got %0d required 4", cyc - last_t);
          end
        end
        last_t = cyc; exp_next = ~gp; grants++;
        e.pipe = gp; e.data = op_exp(gp ? o2 : o1);
        sb.push_back(e);
      end
      vectors++;
      if (f.req2_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fixed_pri: got pipe2 grant required pipe1 only");
      end
      if (f.req1_ready === 1'b1) fix_grants++;
      @(posedge clk); #1;
      o1.x = o1.x + 32'd1; o2.y = o2.y + 32'd1;
      a.req1_bus = o1; a.req2_bus = o2;
    end
    a.req1_valid = 1'b0; a.req2_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((a.rsp1_valid === 1'b1 || a.rsp2_valid === 1'b1) && sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if (a.rsp2_valid !== e.pipe || a.rsp_data !== e.data) begin
          miscompares++;
          $display("FAIL arb_drain: got pipe%0d %h required pipe%0d %h",
                   a.rsp2_valid + 1, a.rsp_data, e.pipe + 1, e.data);
        end
      end
    end
    vectors++;
    if (grants < 6 || fix_grants < 6 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL arb_counts: got grants=%0d fixed=%0d pending=%0d required >=6 >=6 0",
               grants, fix_grants, sb.size());
    end
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    mul_op_t     op;
    bit          seen;
    logic [31:0] d;
    op = '{use_high: 1'b0, is_unsigned: 1'b1, x: 32'd11, y: 32'd13};
    @(posedge clk); #1;
    a.req1_valid = 1'b1; a.req1_bus = op;
    @(negedge clk);
    vectors++;
    if (a.req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_grant: got %b required 1", a.req1_ready);
    end
    @(posedge clk); #1;
    a.req1_valid = 1'b0;
    @(posedge clk); #1;
    a.flush = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a.mul_en, a.mul_ok} !== 2'b11) begin
      miscompares++;
      $display("FAIL flush_on_ok: got en/ok=%b required 11", {a.mul_en, a.mul_ok});
    end
    @(posedge clk); #1;
    a.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({a.rsp1_valid, a.rsp2_valid, a.busy, a.mul_en} !== 4'd0) begin
        miscompares++;
        $display("FAIL flush_kill[%0d]: got %b required 0000", i,
                 {a.rsp1_valid, a.rsp2_valid, a.busy, a.mul_en});
      end
      @(posedge clk); #1;
    end
    // Flush in IDLE blocks a new grant
    a.flush = 1'b1; a.req2_valid = 1'b1;
    a.req2_bus = '{use_high: 1'b0, is_unsigned: 1'b0, x: 32'd9, y: 32'hFFFF_FFFF};
    @(negedge clk);
    vectors++;
    if ({a.req1_ready, a.req2_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_idle: got %b required 00", {a.req1_ready, a.req2_ready});
    end
    @(posedge clk); #1;
    a.flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (a.req2_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_release: got %b required 1", a.req2_ready);
    end
    @(posedge clk); #1;
    a.req2_valid = 1'b0;
    seen = 1'b0; d = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (a.rsp2_valid === 1'b1) begin seen = 1'b1; d = a.rsp_data; end
    end
    vectors++;
    if (!seen || d !== 32'hFFFF_FFF7) begin
      miscompares++;
      $display("FAIL flush_after_rsp: got seen=%0d %h required seen=1 fffffff7", seen, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int en_cnt;
    stall = 1'b1;
    @(posedge clk); #1;
    a.req2_valid = 1'b1;
    a.req2_bus = '{use_high: 1'b0, is_unsigned: 1'b1, x: 32'd5, y: 32'd5};
    @(negedge clk);
    vectors++;
    if (a.req2_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_grant: got %b required 1", a.req2_ready);
    end
    @(posedge clk); #1;
    a.req2_valid = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a.mul_en === 1'b1) en_cnt++;
      else break;
    end
    vectors++;
    if (en_cnt !== 15) begin
      miscompares++;
      $display("FAIL timeout_en_cycles: got %0d required 15", en_cnt);
    end
    vectors++;
    if ({a.timeout_err, a.busy, a.rsp1_valid, a.rsp2_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL timeout_pulse: got %b required 1000",
               {a.timeout_err, a.busy, a.rsp1_valid, a.rsp2_valid});
    end
    @(negedge clk);
    vectors++;
    if (a.timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_one_shot: got %b required 0", a.timeout_err);
    end
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_hold_and_reset();
    exp_t    e;
    bit      seen;
    mul_op_t op;
    a.rsp_ready = 1'b0;
    op = '{use_high: 1'b0, is_unsigned: 1'b0, x: 32'hFFFF_FFFD, y: 32'd100};
    @(posedge clk); #1;
    a.req1_valid = 1'b1; a.req1_bus = op;
    @(negedge clk);
    vectors++;
    if (a.req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_grant: got %b required 1", a.req1_ready);
    end
    e.pipe = 1'b0; e.data = op_exp(op);
    sb.push_back(e);
    @(posedge clk); #1;
    a.req1_valid = 1'b0; a.req2_valid = 1'b1;
    a.req2_bus = '{use_high: 1'b0, is_unsigned: 1'b1, x: 32'd8, y: 32'd8};
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (a.rsp1_valid === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({a.rsp1_valid, a.rsp2_valid, a.req2_ready} !== 3'b100 || a.rsp_data !== e.data) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got %b %h required 100 %h", i,
                 {a.rsp1_valid, a.rsp2_valid, a.req2_ready}, a.rsp_data, e.data);
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({a.rsp1_valid, a.req2_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_release: got %b required 01", {a.rsp1_valid, a.req2_ready});
    end
    @(posedge clk); #1;
    a.req2_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({a.busy, a.mul_en, a.rsp1_valid, a.rsp2_valid, a.timeout_err, a.mul_signed,
         a.mul_use_high, a.req1_ready, a.req2_ready} !== 9'd0 ||
        {a.mul_x, a.mul_y, a.rsp_data} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_mid_busy: got %b %h required all zero", {a.busy, a.mul_en, a.rsp1_valid,
               a.rsp2_valid, a.timeout_err}, {a.mul_x, a.mul_y, a.rsp_data});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({a.rsp1_valid, a.rsp2_valid, a.timeout_err, a.busy} !== 4'd0) begin
        miscompares++;
        $display("FAIL post_reset_quiet[%0d]: got %b required 0000", i,
                 {a.rsp1_valid, a.rsp2_valid, a.timeout_err, a.busy});
      end
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_pipe2();
    test_arbitration();
    test_flush();
    test_timeout();
    test_hold_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion required completion by 200us");
    $fatal(1, "bench timeout");
  end
endmodule
